// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data-island packet constants and types.
// Used by the audio InfoFrame receiver and its BCH checker.
package hdmi_packet_pkg;

  localparam logic [7:0] AUDIO_INFO_FRAME_TYPE    = 8'h84;
  localparam logic [7:0] AUDIO_INFO_FRAME_VERSION = 8'h01;
  localparam logic [4:0] AUDIO_INFO_FRAME_LENGTH  = 5'd10;

  // x^8+x^7+x^6+1, bit-reversed for LSB-first right-shifting
  localparam logic [7:0] BCH_GENERATOR = 8'h83;

  typedef struct packed {
    logic [2:0] channel_count;
    logic [3:0] coding_type;
    logic [7:0] channel_allocation;
    logic       down_mix_inhibited;
    logic [3:0] level_shift_value;
    logic [1:0] lfe_playback_level;
  } audio_fields_t;

  function automatic logic [7:0] bch_step(
    input logic [7:0] p,
    input logic       b
  );
    logic fb;
    fb = p[0] ^ b;
    return (p >> 1) ^ (fb ? BCH_GENERATOR : 8'h00);
  endfunction

endpackage

// File: rtl/packet_bch_checker.sv
// Serial BCH parity over one packet channel, LSB first.
// Flags a mismatch between computed and received ECC byte.
module packet_bch_checker
  import hdmi_packet_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int DATA_CYCLES    = 24
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [4:0]                cnt_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  output logic                      mismatch_o
);

  localparam logic [4:0] LAST_DATA = 5'(DATA_CYCLES);
  localparam logic [4:0] BPC       = 5'(BITS_PER_CYCLE);

  logic [7:0] parity_q, parity_d;
  logic [7:0] recv_q, recv_d;
  logic [7:0] seed;
  logic [2:0] slot;

  // Parity during data cycles, ECC byte collection afterwards
  always_comb begin
    parity_d = parity_q;
    recv_d   = recv_q;
    seed     = (cnt_i == 5'd0) ? 8'h00 : parity_q;
    slot     = 3'((cnt_i - LAST_DATA) * BPC);
    if (en_i) begin
      if (cnt_i < LAST_DATA) begin
        parity_d = seed;
        for (int b = 0; b < BITS_PER_CYCLE; b++)
          parity_d = bch_step(parity_d, bits_i[b]);
      end else begin
        recv_d[slot +: BITS_PER_CYCLE] = bits_i;
      end
    end
  end

  // Parity and received-byte registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      parity_q <= '0;
      recv_q   <= '0;
    end else begin
      parity_q <= parity_d;
      recv_q   <= recv_d;
    end
  end

  assign mismatch_o = (parity_q != recv_q);

endmodule

// File: rtl/audio_info_frame_receiver.sv
// HDMI audio InfoFrame receiver: capture, check, latch fields.
// Optional ECC checking under AUDIO_INFO_FRAME_ECC_CHECK_EN.
module audio_info_frame_receiver
  import hdmi_packet_pkg::*;
#(
  parameter bit DROP_ON_CHECKSUM_ERROR = 1'b1
) (
  input  logic            clk_pixel,
  input  logic            reset,
  input  logic            packet_enable,
  input  logic            header_bit,
  input  logic [3:0][1:0] sub_bits,
  output logic            frame_valid,
  output logic            checksum_error,
  output logic            ecc_error,
  output logic [2:0]      channel_count,
  output logic [3:0]      coding_type,
  output logic [7:0]      channel_allocation,
  output logic            down_mix_inhibited,
  output logic [3:0]      level_shift_value,
  output logic [1:0]      lfe_playback_level,
  output logic            fields_present
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_BLOCK
  } state_e;

  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic cap_en;
  logic xfer_q, xfer_d;

  logic [23:0]      hdr_q, hdr_d;
  logic [3:0][55:0] pb_q, pb_d;

  logic             eval_valid_q;
  logic [23:0]      eval_hdr_q;
  logic [3:0][55:0] eval_pb_q;
  logic             ecc_bad;

  audio_fields_t fields_q, fields_d, upd;
  logic present_q, present_d;
  logic fv_q, fv_d;
  logic ce_q, ce_d;
  logic ee_q, ee_d;
  logic [7:0] sum;
  logic type_ok;

  // Packet framing: wait for a rising enable, count 32 bits
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_en  = 1'b0;
    unique case (state_q)
      S_BLOCK: begin
        if (!packet_enable) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (packet_enable) begin
          cap_en  = 1'b1;
          cnt_d   = 5'd1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (packet_enable) begin
          cap_en = 1'b1;
          cnt_d  = cnt_q + 5'd1;
        end else begin
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = 5'd0;
        state_d = S_BLOCK;
      end
    endcase
    xfer_d = cap_en && (cnt_q == 5'd31);
  end

  // Framing state, counter and transfer request
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q <= S_BLOCK;
      cnt_q   <= '0;
      xfer_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
    end
  end

  // Capture header and subpacket payload bits
  always_comb begin
    hdr_d = hdr_q;
    pb_d  = pb_q;
    if (cap_en) begin
      if (cnt_q < 5'd24) hdr_d[cnt_q] = header_bit;
      if (cnt_q < 5'd28)
        for (int i = 0; i < 4; i++)
          pb_d[i][{cnt_q, 1'b0} +: 2] = sub_bits[i];
    end
  end

  // Capture registers
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      hdr_q <= '0;
      pb_q  <= '0;
    end else begin
      hdr_q <= hdr_d;
      pb_q  <= pb_d;
    end
  end

  // Evaluation stage, loaded one cycle after bit 31
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      eval_valid_q <= 1'b0;
      eval_hdr_q   <= '0;
      eval_pb_q    <= '0;
    end else begin
      eval_valid_q <= xfer_q;
      if (xfer_q) begin
        eval_hdr_q <= hdr_q;
        eval_pb_q  <= pb_q;
      end
    end
  end

`ifdef AUDIO_INFO_FRAME_ECC_CHECK_EN
  logic       hdr_mm;
  logic [3:0] sub_mm;
  logic       eval_ecc_q;

  packet_bch_checker #(
    .BITS_PER_CYCLE(1),
    .DATA_CYCLES(24)
  ) u_hdr_bch (
    .clk_i     (clk_pixel),
    .rst_i     (reset),
    .en_i      (cap_en),
    .cnt_i     (cnt_q),
    .bits_i    (header_bit),
    .mismatch_o(hdr_mm)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sub_bch
    packet_bch_checker #(
      .BITS_PER_CYCLE(2),
      .DATA_CYCLES(28)
    ) u_sub_bch (
      .clk_i     (clk_pixel),
      .rst_i     (reset),
      .en_i      (cap_en),
      .cnt_i     (cnt_q),
      .bits_i    (sub_bits[g]),
      .mismatch_o(sub_mm[g])
    );
  end

  // Snapshot ECC verdict alongside the evaluation data
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) eval_ecc_q <= 1'b0;
    else if (xfer_q) eval_ecc_q <= hdr_mm | (|sub_mm);
  end

  assign ecc_bad = eval_ecc_q;
`else
  assign ecc_bad = 1'b0;
`endif

  // Type match, checksum and outcome selection
  always_comb begin
    sum = eval_hdr_q[7:0] + eval_hdr_q[15:8] + eval_hdr_q[23:16];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 7; j++)
        sum = sum + eval_pb_q[i][8*j +: 8];
    type_ok = (eval_hdr_q[7:0] == AUDIO_INFO_FRAME_TYPE) &&
              (eval_hdr_q[15:8] == AUDIO_INFO_FRAME_VERSION) &&
              (eval_hdr_q[20:16] == AUDIO_INFO_FRAME_LENGTH);

    upd.channel_count      = eval_pb_q[0][10:8];
    upd.coding_type        = eval_pb_q[0][15:12];
    upd.channel_allocation = eval_pb_q[0][39:32];
    upd.down_mix_inhibited = eval_pb_q[0][47];
    upd.level_shift_value  = eval_pb_q[0][46:43];
    upd.lfe_playback_level = eval_pb_q[0][41:40];

    fields_d  = fields_q;
    present_d = present_q;
    fv_d      = 1'b0;
    ce_d      = 1'b0;
    ee_d      = 1'b0;
    if (eval_valid_q) begin
      ee_d = ecc_bad;
      ce_d = type_ok && (sum != 8'h00);
      if (type_ok && !ecc_bad &&
          ((sum == 8'h00) || !DROP_ON_CHECKSUM_ERROR)) begin
        fv_d      = 1'b1;
        fields_d  = upd;
        present_d = 1'b1;
      end
    end
  end

  // Output pulse and field registers
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      fields_q  <= '0;
      present_q <= 1'b0;
      fv_q      <= 1'b0;
      ce_q      <= 1'b0;
      ee_q      <= 1'b0;
    end else begin
      fields_q  <= fields_d;
      present_q <= present_d;
      fv_q      <= fv_d;
      ce_q      <= ce_d;
      ee_q      <= ee_d;
    end
  end

  assign frame_valid        = fv_q;
  assign checksum_error     = ce_q;
  assign ecc_error          = ee_q;
  assign channel_count      = fields_q.channel_count;
  assign coding_type        = fields_q.coding_type;
  assign channel_allocation = fields_q.channel_allocation;
  assign down_mix_inhibited = fields_q.down_mix_inhibited;
  assign level_shift_value  = fields_q.level_shift_value;
  assign lfe_playback_level = fields_q.lfe_playback_level;
  assign fields_present     = present_q;

endmodule

// File: doc/audio_info_frame_receiver.md
# audio_info_frame_receiver

Receive-side counterpart of the HDMI audio InfoFrame path. The block sits behind the TMDS/TERC4 data-island decoder in the pixel clock domain and deserializes 32-cycle data-island packets. It checks header ECC and the CEA-861 checksum, and recognizes Audio InfoFrames (type 0x84, version 1, length 10). It then latches the decoded audio fields and pulses a strobe for downstream audio-clock and channel-mapping logic.

## Interface
- `DROP_ON_CHECKSUM_ERROR`, default 1: 1 = a frame with a bad checksum does not update the latched fields; 0 = update anyway and flag the error.
- `clk_pixel`  in  1  pixel clock. Single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `packet_enable`  in  1  high for each of the 32 cycles of a packet. Its rising edge marks bit 0.
- `header_bit`  in  1  channel-0 header bit for the current cycle.
- `sub_bits`  in  [3:0][1:0]  bits 2k+1 and 2k of subpackets 0..3 on cycle k.
- `frame_valid`  out  1  one-cycle pulse: the fields below were just updated.
- `checksum_error`  out  1  one-cycle pulse: an audio InfoFrame arrived with a bad checksum.
- `ecc_error`  out  1  one-cycle pulse: a header or subpacket BCH mismatch (macro-dependent).
- `channel_count`  out  3  PB1[2:0].
- `coding_type`  out  4  PB1[7:4].
- `channel_allocation`  out  8  PB4.
- `down_mix_inhibited`  out  1  PB5[7].
- `level_shift_value`  out  4  PB5[6:3].
- `lfe_playback_level`  out  2  PB5[1:0].
- `fields_present`  out  1  sticky. Set on the first `frame_valid`; cleared only by reset.

## Operation
- Bit counter, 5 bits. Counts while `packet_enable`=1 and wraps 31→0.
- On cycle k, capture:
  - header bit k (LSB first): bits 0-23 → HB0..HB2, bits 24-31 → header ECC byte;
  - subpacket i bits 2k and 2k+1: bits 0-55 → PB(7i)..PB(7i+6), bits 56-63 → ECC byte i.
- At count=31 with `packet_enable`=1, copy the capture registers into an evaluation stage. This frees capture for a back-to-back packet that starts on the next cycle.
- Evaluation (one cycle):
  - Type match: HB0=0x84, HB1=0x01, HB2[4:0]=10.
  - Checksum: (HB0+HB1+HB2+PB0+…+PB27) mod 256 = 0x00, using an 8-bit wrapping adder.
  - The checksum is evaluated only on a type match.
- Outcomes:
  - Non-matching packet types are ignored silently: no pulses, fields unchanged.
  - Match, good checksum, no ECC error: update all fields and pulse `frame_valid`.
  - Match, bad checksum: pulse `checksum_error`. Update fields and pulse `frame_valid` only if `DROP_ON_CHECKSUM_ERROR`=0.
  - Any ECC error: pulse `ecc_error` regardless of type; never update fields.
- `packet_enable` falls before count 31: abort. Counter returns to 0, partial data is discarded, no pulses.
- Reserved bits (PB1[3], PB5[2], PB6..PB27) are checked only via the checksum; non-zero values are accepted.

## Timing
- Latency: the last bit is captured in cycle 31 (edge N). Pulses and fields are valid after edge N+2: one transfer cycle, one evaluation register.
- Back-to-back packets (64 contiguous enable cycles) give two pulses exactly 32 cycles apart.
- Pulses are exactly one cycle wide. `checksum_error` and `ecc_error` may coincide with each other, never with a `frame_valid` whose fields were suppressed.
- Reset (any time, including mid-packet): counter=0, capture/eval cleared, all outputs 0. The first packet after reset must begin with a fresh `packet_enable` rising edge.

## Configuration
- `AUDIO_INFO_FRAME_ECC_CHECK_EN`
  - Defined: the BCH(32,24) header and BCH(64,56) subpacket parity are computed serially during capture, generator x^8+x^7+x^6+1, LSB first. They are compared with the received ECC bytes at evaluation. No correction is performed.
  - Undefined: the ECC logic is absent, ECC bytes are ignored, and `ecc_error` is tied to 0.

## Structure
- Shared package `hdmi_packet_pkg`:
  - packet type constants (AUDIO_INFO_FRAME_TYPE=8'h84, version, length);
  - the BCH generator constant;
  - a typedef for the decoded audio InfoFrame field struct.
- One sub-module, `packet_bch_checker`:
  - serial 8-bit LFSR parity with one instance for the header and four for the subpackets;
  - instantiated only under the macro.

## Test plan
- Valid frame with HB=84/01/0A, PB1=0x01, PB4=0x00, PB5=0x00, PB0=0x70 and correct ECC → `frame_valid` 2 cycles after bit 31, `channel_count`=1, `fields_present`=1.
- Same frame with PB0=0x6F and `DROP_ON_CHECKSUM_ERROR`=1 → `checksum_error` pulse, no `frame_valid`, fields keep their prior values.
- Frame with PB4=0x13, PB5=0xB9, PB0 adjusted → `channel_allocation`=0x13, `down_mix_inhibited`=1, `level_shift_value`=7, `lfe_playback_level`=1.
- `packet_enable` dropped at cycle 17, then a valid packet follows → no pulse for the first, `frame_valid` for the second; two contiguous packets → pulses 32 cycles apart.
- With macro defined, flip header ECC bit 3 → `ecc_error` pulse, fields unchanged. With macro undefined, same stimulus → `frame_valid`.
- Assert `reset` at cycle 20 of a packet → all outputs 0 within the same cycle (async), and no pulse follows.
